i2c_ccd_slave: RTL and testbench

- I2C responder that models the CCD/CMOS sensor's register interface (device 0xBA write / 0xBB read, 8-bit register address, 16-bit big-endian data).
- Oversamples SCL/SDA on the 50 MHz system clock, ACKs its own address, and stores written words in an internal register file.
- Serves reads and exposes a write-strobe port plus a side read port to the rest of the design.
- Serves as the bus-level sensor stand-in for the camera configuration master, in simulation and in loopback builds.

---
 rtl/i2c_ccd_slave.sv | 181 ++++++++++++++++++
 tb/tb_i2c_ccd_slave.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ccd_slave.sv
// I2C register-file responder for the CCD sensor interface (0xBA wr / 0xBB rd, 8-bit addr, 16-bit data).
// Bus events act 3 iCLK after the pin change; the master drives all pacing, SDA is open-drain.
module i2c_ccd_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5D,
  parameter int         REG_AW     = 8,
  parameter int         REG_DW     = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              I2C_SCLK,
  inout  wire               I2C_SDAT,
  output logic              oREG_WR,
  output logic [REG_AW-1:0] oREG_ADDR,
  output logic [REG_DW-1:0] oREG_WDATA,
  input  logic [REG_AW-1:0] iRD_ADDR,
  output logic [REG_DW-1:0] oRD_DATA,
  output logic              oBUSY
);

  typedef enum logic [2:0] {
    IDLE, DEV_ADDR, REG_ADDR, WR_MSB, WR_LSB, RD_MSB, RD_LSB, IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        scl_sync_q, sda_sync_q;
  logic              scl_prev_q, sda_prev_q;
  logic              scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        rx_q, rx_d, tx_q, tx_d, hold_q, hold_d, rx_byte;
  logic [REG_AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic              oe_q, oe_d, wr_q, wr_d, busy_q, busy_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [REG_DW-1:0] reg_wdata_q, reg_wdata_d, rd_data_q;
  logic [REG_DW-1:0] regs_q [2**REG_AW];
  logic              addr_match, ack_slot, rd_phase;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_evt = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_evt  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte   = {rx_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + REG_AW'(1);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Byte-level transitions happen on the 9th (ACK) rising edge; START/STOP override everything.
  always_comb begin
    state_d = state_q;
    if (start_evt) begin
      state_d = DEV_ADDR;
    end else if (stop_evt) begin
      state_d = IDLE;
    end else if (scl_rise && cnt_q == 4'd8) begin
      case (state_q)
        DEV_ADDR: state_d = !addr_match ? IGNORE : (rx_q[0] ? RD_MSB : REG_ADDR);
        REG_ADDR: state_d = WR_MSB;
        WR_MSB:   state_d = WR_LSB;
        WR_LSB:   state_d = WR_MSB;
        RD_MSB:   state_d = sda_s ? IGNORE : RD_LSB;
        RD_LSB:   state_d = sda_s ? IGNORE : RD_MSB;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    addr_match = (rx_q[7:1] == SLAVE_ADDR);
    ack_slot   = ((state_q == DEV_ADDR) && addr_match) || (state_q == REG_ADDR) ||
                 (state_q == WR_MSB) || (state_q == WR_LSB);
    rd_phase   = (state_q == RD_MSB) || (state_q == RD_LSB);
  end

  always_comb begin
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    ptr_d       = ptr_q;
    oe_d        = oe_q;
    wr_d        = 1'b0;
    busy_d      = busy_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    if (start_evt || stop_evt) begin
      cnt_d  = 4'd0;
      oe_d   = 1'b0;
      busy_d = start_evt;
    end else if (scl_rise) begin
      if (cnt_q != 4'd8) begin
        cnt_d = cnt_q + 4'd1;
        rx_d  = rx_byte;
        tx_d  = {tx_q[6:0], 1'b0};
        if (cnt_q == 4'd7) begin
          case (state_q)
            REG_ADDR: ptr_d = REG_AW'(rx_byte);
            WR_MSB:   hold_d = rx_byte;
            WR_LSB: begin
              wr_d        = 1'b1;
              reg_addr_d  = ptr_q;
              reg_wdata_d = {hold_q, rx_byte};
              ptr_d       = ptr_inc;
            end
            default: ;
          endcase
        end
      end else begin
        cnt_d = 4'd0;
        case (state_q)
          DEV_ADDR: if (addr_match && rx_q[0]) tx_d = regs_q[ptr_q][REG_DW-1 -: 8];
          RD_MSB:   if (!sda_s) tx_d = regs_q[ptr_q][7:0];
          RD_LSB: begin
            ptr_d = ptr_inc;
            tx_d  = regs_q[ptr_inc][REG_DW-1 -: 8];
          end
          default: ;
        endcase
      end
    end else if (scl_fall) begin
      // Read bits go out MSB first while cnt<8; the 9th slot belongs to the master.
      if (rd_phase) oe_d = (cnt_q != 4'd8) && !tx_q[7];
      else          oe_d = (cnt_q == 4'd8) && ack_slot;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      hold_q      <= '0;
      ptr_q       <= '0;
      oe_q        <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      scl_sync_q  <= {scl_sync_q[0], I2C_SCLK};
      sda_sync_q  <= {sda_sync_q[0], I2C_SDAT};
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
      oe_q        <= oe_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rd_data_q   <= regs_q[iRD_ADDR];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
    end else if (wr_d) begin
      regs_q[reg_addr_d] <= reg_wdata_d;
    end
  end

  assign I2C_SDAT   = oe_q ? 1'b0 : 1'bz;
  assign oREG_WR    = wr_q;
  assign oREG_ADDR  = reg_addr_q;
  assign oREG_WDATA = reg_wdata_q;
  assign oRD_DATA   = rd_data_q;
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_i2c_ccd_slave.sv
// Bench for i2c_ccd_slave: bit-banged I2C master, commit scoreboard, side-port checks.
module tb_i2c_ccd_slave;
  localparam int   Q   = 8;
  localparam logic ACK = 1'b0;
  localparam logic NAK = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_scl;
  logic        m_sda_oe;
  logic [7:0]  rd_addr;
  wire         sda;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] rd_data;
  logic        busy;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  i2c_ccd_slave dut (
    .iCLK(clk), .iRST_N(rst_n), .I2C_SCLK(m_scl), .I2C_SDAT(sda),
    .oREG_WR(reg_wr), .oREG_ADDR(reg_addr), .oREG_WDATA(reg_wdata),
    .iRD_ADDR(rd_addr), .oRD_DATA(rd_data), .oBUSY(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          wr_pulses = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;
  logic        sc_watch = 1'b0, sc_next = 1'b0;
  logic [15:0] sc_old, sc_new;
  logic        watch_nodrive = 1'b0, slave_drove = 1'b0;
  logic [7:0]  rbyte;
  int          pulses_before;

  logic [23:0] cfg [25] = '{
    24'h20C000, 24'h0907C0, 24'h050000, 24'h060019, 24'h2B000B,
    24'h2C000F, 24'h2D000F, 24'h2E000B, 24'h010014, 24'h020000,
    24'h030797, 24'h040A1F, 24'h220011, 24'h230011, 24'h100051,
    24'h111807, 24'h120002, 24'h100053, 24'h212000, 24'h4901A8,
    24'h1E4006, 24'h350014, 24'h0A8000, 24'h0B0000, 24'h07FFFF
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected commits whenever the DUT pulses oREG_WR.
  always @(posedge clk) begin
    #1;
    if (watch_nodrive && sda === 1'b0 && !m_sda_oe) slave_drove = 1'b1;
    if (sc_next) begin
      check("same_cycle_new", 32'(rd_data), 32'(sc_new));
      sc_next = 1'b0;
    end
    if (rst_n && reg_wr) begin
      wr_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got addr %h data %h, expected no pulse", reg_addr, reg_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("reg_wr", 32'({reg_addr, reg_wdata}), 32'(exp_e));
      end
      if (sc_watch && reg_addr == rd_addr) begin
        check("same_cycle_old", 32'(rd_data), 32'(sc_old));
        sc_next  = 1'b1;
        sc_watch = 1'b0;
      end
    end
  end

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; qw(); m_scl = 1'b1; qw(); m_sda_oe = 1'b1; qw(); m_scl = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; qw(); m_scl = 1'b1; qw(); m_sda_oe = 1'b0; qw();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda_oe = ~b[i]; qw(); m_scl = 1'b1; qw(); qw(); m_scl = 1'b0; qw();
    end
  endtask

  task automatic wb(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    send_bits(b);
    m_sda_oe = 1'b0; qw(); m_scl = 1'b1; qw(); a = sda; qw(); m_scl = 1'b0; qw();
    check(name, 32'(a), 32'(exp_ack));
  endtask

  task automatic rb(input logic mack, output logic [7:0] b);
    m_sda_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      qw(); m_scl = 1'b1; qw(); b[i] = sda; qw(); m_scl = 1'b0;
    end
    m_sda_oe = mack; qw(); m_scl = 1'b1; qw(); qw(); m_scl = 1'b0;
  endtask

  task automatic wr1(input logic [7:0] ra, input logic [15:0] d);
    exp_q.push_back({ra, d});
    i2c_start();
    wb(8'hBA, ACK, "ack_dev"); wb(ra, ACK, "ack_reg");
    wb(d[15:8], ACK, "ack_msb"); wb(d[7:0], ACK, "ack_lsb");
    i2c_stop();
  endtask

  task automatic side_rd(input logic [7:0] a, input logic [15:0] exp, input string name);
    @(negedge clk); rd_addr = a;
    @(negedge clk); check(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; m_scl = 1'b1; m_sda_oe = 1'b0; rd_addr = 8'h00;
    sc_old = 16'h0; sc_new = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_wr", 32'(reg_wr), 32'(0));
    check("rst_addr", 32'(reg_addr), 32'(0));
    check("rst_wdata", 32'(reg_wdata), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_sda", 32'(sda), 32'(1));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single write and side read-back
    wr1(8'h09, 16'h07C0);
    check("t1_pending", 32'(exp_q.size()), 32'(0));
    side_rd(8'h09, 16'h07C0, "t1_rd");

    // Wrong device address: never ACKed, nothing stored
    watch_nodrive = 1'b1; slave_drove = 1'b0;
    i2c_start();
    wb(8'hB8, NAK, "t2_dev"); wb(8'h09, NAK, "t2_reg");
    wb(8'h12, NAK, "t2_msb"); wb(8'h34, NAK, "t2_lsb");
    i2c_stop();
    watch_nodrive = 1'b0;
    check("t2_no_drive", 32'(slave_drove), 32'(0));
    side_rd(8'h09, 16'h07C0, "t2_rd");

    // Pointer write, repeated START, two-byte read
    i2c_start();
    wb(8'hBA, ACK, "t3_dev_w");
    check("t3_busy", 32'(busy), 32'(1));
    wb(8'h09, ACK, "t3_reg");
    i2c_start();
    wb(8'hBB, ACK, "t3_dev_r");
    rb(1'b1, rbyte); check("t3_rd_msb", 32'(rbyte), 32'(8'h07));
    rb(1'b0, rbyte); check("t3_rd_lsb", 32'(rbyte), 32'(8'hC0));
    i2c_stop();
    check("t3_busy_after_stop", 32'(busy), 32'(0));

    // Burst write with same-cycle side read, then pointer wrap
    @(negedge clk);
    rd_addr = 8'h2B; sc_old = 16'h0000; sc_new = 16'h000B; sc_watch = 1'b1;
    exp_q.push_back(24'h2B000B); exp_q.push_back(24'h2C000F);
    i2c_start();
    wb(8'hBA, ACK, "t4_dev"); wb(8'h2B, ACK, "t4_reg");
    wb(8'h00, ACK, "t4_d0"); wb(8'h0B, ACK, "t4_d1");
    wb(8'h00, ACK, "t4_d2"); wb(8'h0F, ACK, "t4_d3");
    i2c_stop();
    check("t4_same_cycle_seen", 32'(sc_watch), 32'(0));
    side_rd(8'h2B, 16'h000B, "t4_rd_2b");
    side_rd(8'h2C, 16'h000F, "t4_rd_2c");
    exp_q.push_back(24'hFFAAAA); exp_q.push_back(24'h005555);
    i2c_start();
    wb(8'hBA, ACK, "t4w_dev"); wb(8'hFF, ACK, "t4w_reg");
    wb(8'hAA, ACK, "t4w_d0"); wb(8'hAA, ACK, "t4w_d1");
    wb(8'h55, ACK, "t4w_d2"); wb(8'h55, ACK, "t4w_d3");
    i2c_stop();
    side_rd(8'hFF, 16'hAAAA, "t4_rd_ff");
    side_rd(8'h00, 16'h5555, "t4_rd_00");

    // Abort after the MSB: no commit
    pulses_before = wr_pulses;
    i2c_start();
    wb(8'hBA, ACK, "t5_dev"); wb(8'h20, ACK, "t5_reg"); wb(8'hC0, ACK, "t5_msb");
    i2c_stop();
    check("t5_no_pulse", 32'(wr_pulses - pulses_before), 32'(0));
    side_rd(8'h20, 16'h0000, "t5_rd_20");

    // Reset while the slave holds an ACK low
    i2c_start();
    send_bits(8'hBA);
    m_sda_oe = 1'b0; qw();
    check("t5_ack_driven", 32'(sda), 32'(0));
    @(negedge clk); rst_n = 1'b0; #1;
    check("t5_rst_sda", 32'(sda), 32'(1));
    check("t5_rst_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    i2c_stop();
    side_rd(8'h09, 16'h0000, "t5_regs_cleared");

    // Sensor configuration sequence
    pulses_before = wr_pulses;
    for (int k = 0; k < 25; k++) wr1(cfg[k][23:16], cfg[k][15:0]);
    check("t6_pulses", 32'(wr_pulses - pulses_before), 32'(25));
    side_rd(8'h09, 16'h07C0, "t6_rd_09");
    side_rd(8'h20, 16'hC000, "t6_rd_20");
    side_rd(8'h11, 16'h1807, "t6_rd_11");
    side_rd(8'h49, 16'h01A8, "t6_rd_49");
    side_rd(8'h22, 16'h0011, "t6_rd_22");

    repeat (5) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
